miniscope_readout: RTL

MINISCOPE_READOUT -- requirements
Module: miniscope_readout

---
 rtl/miniscope_readout_pkg.sv | 24 ++
 rtl/miniscope_readout.sv | 137 +++++++++++++
 2 files changed

// File: rtl/miniscope_readout_pkg.sv
// Shared miniscope constants: FSM state encoding and the stream frame markers
// used by both the storage and readout blocks.
package miniscope_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_READ    = 2'd2,
    ST_TRAILER = 2'd3
  } mini_state_t;

  localparam logic [3:0] MINI_HDR_MARK = 4'hB;
  localparam logic [3:0] MINI_TRL_MARK = 4'hE;

  function automatic logic [15:0] mini_header_word(input logic [5:0] tbins);
    return {MINI_HDR_MARK, 6'h00, tbins};
  endfunction

  function automatic logic [15:0] mini_trailer_word(input logic [1:0] perr,
                                                    input logic [5:0] tbins);
    return {MINI_TRL_MARK, perr, 4'h0, tbins};
  endfunction

endpackage

// File: rtl/miniscope_readout.sv
// Miniscope RAM readout: frames tbins RAM words between a header and a trailer
// as one gap-free registered stream, tracking parity errors per readout.
module miniscope_readout
  import miniscope_readout_pkg::*;
#(
  parameter int RAM_ADRB  = 11,
  parameter int RAM_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     mini_rd_start,
  input  logic [RAM_ADRB-1:0]      mini_rd_adr,
  input  logic [5:0]               mini_tbins,
  output logic [RAM_ADRB-1:0]      fifo_radr_mini,
  input  logic [2*RAM_WIDTH-1:0]   fifo_rdata_mini,
  input  logic [1:0]               parity_err_mini,
  output logic [2*RAM_WIDTH-1:0]   mini_data,
  output logic                     mini_valid,
  output logic                     mini_busy,
  output logic                     mini_done,
  output logic [7:0]               mini_perr_cnt
);

  localparam int DW = 2 * RAM_WIDTH;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  mini_state_t           state_q;
  mini_state_t           state_d;
  logic                  accept;
  logic                  ld_hdr;
  logic                  ld_dat;
  logic                  ld_trl;
  logic [RAM_ADRB-1:0]   radr_p0;
  logic [5:0]            iss_left_p0;
  logic [5:0]            dat_left_q;
  logic [5:0]            tbins_q;
  logic [1:0]            perr_sticky;

  assign accept    = reset_n && (state_q == ST_IDLE) && mini_rd_start;
  assign mini_busy = (state_q != ST_IDLE);

  // The first address bypasses the register so word 0 lands right after the header.
  assign fifo_radr_mini = accept ? mini_rd_adr : radr_p0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ld_hdr  = 1'b0;
    ld_dat  = 1'b0;
    ld_trl  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_HEADER;
          ld_hdr  = 1'b1;
        end
      end
      ST_HEADER, ST_READ: begin
        if (dat_left_q == 6'd0) begin
          state_d = ST_TRAILER;
          ld_trl  = 1'b1;
        end else begin
          state_d = ST_READ;
          ld_dat  = 1'b1;
        end
      end
      ST_TRAILER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Address stage: one address per cycle until all tbins have been issued.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      radr_p0     <= '0;
      iss_left_p0 <= '0;
    end else if (accept) begin
      if (mini_tbins > 6'd1) begin
        radr_p0     <= mini_rd_adr + RAM_ADRB'(1);
        iss_left_p0 <= mini_tbins - 6'd2;
      end else begin
        radr_p0     <= mini_rd_adr;
        iss_left_p0 <= 6'd0;
      end
    end else if (mini_busy && (iss_left_p0 != 6'd0)) begin
      radr_p0     <= radr_p0 + RAM_ADRB'(1);
      iss_left_p0 <= iss_left_p0 - 6'd1;
    end
  end

  // Output stage: RAM data arrives one cycle after its address and is registered here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mini_data     <= '0;
      mini_valid    <= 1'b0;
      mini_done     <= 1'b0;
      mini_perr_cnt <= '0;
      perr_sticky   <= '0;
      tbins_q       <= '0;
      dat_left_q    <= '0;
    end else begin
      mini_data  <= '0;
      mini_valid <= 1'b0;
      mini_done  <= 1'b0;
      if (ld_hdr) begin
        mini_data   <= DW'(mini_header_word(mini_tbins));
        mini_valid  <= 1'b1;
        perr_sticky <= 2'b00;
        tbins_q     <= mini_tbins;
        dat_left_q  <= mini_tbins;
      end else if (ld_dat) begin
        mini_data   <= fifo_rdata_mini;
        mini_valid  <= 1'b1;
        dat_left_q  <= dat_left_q - 6'd1;
        perr_sticky <= perr_sticky | parity_err_mini;
        if (|parity_err_mini) begin
          mini_perr_cnt <= sat_inc8(mini_perr_cnt);
        end
      end else if (ld_trl) begin
        mini_data  <= DW'(mini_trailer_word(perr_sticky, tbins_q));
        mini_valid <= 1'b1;
        mini_done  <= 1'b1;
      end
    end
  end

endmodule
